// File: rtl/shift_right_unit.sv
// Purpose: iterative SRL/SRA right shifter, one bit position per clock, start/busy/done handshake.
// Latency: done is high in the cycle after the shamt-th edge following the capture edge (shamt=0: next cycle).
// Backpressure: start is only accepted when not busy (IDLE or DONE); requests during SHIFT are dropped.
module shift_right_unit #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             arith,
    input  logic [SHW-1:0]   shamt,
    input  logic [WIDTH-1:0] inData,
    output logic [WIDTH-1:0] outData,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           stateNext;
    logic [WIDTH-1:0] work;
    logic [SHW-1:0]   count;
    logic             fill;

    // A new operation is accepted whenever the unit is not mid-shift.
    logic             load;
    logic [WIDTH-1:0] shifted;
    logic             lastStep;

    assign load     = (state != SHIFT) && start;
    assign shifted  = {fill, work[WIDTH-1:1]};
    // count never reaches 0 inside SHIFT; <= 1 keeps a stray 0 from looping 2^SHW times.
    assign lastStep = (count <= SHW'(1));

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state and status outputs.
    always_comb begin
        stateNext = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE, DONE: begin
                done = (state == DONE);
                if (start) begin
                    stateNext = (shamt == '0) ? DONE : SHIFT;
                end else begin
                    stateNext = IDLE;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (lastStep) begin
                    stateNext = DONE;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Operand capture, one-bit-per-cycle shifting and result register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            work    <= '0;
            count   <= '0;
            fill    <= 1'b0;
            outData <= '0;
        end else if (load) begin
            work  <= inData;
            count <= shamt;
            fill  <= arith & inData[WIDTH-1];
            if (shamt == '0) begin
                outData <= inData;
            end
        end else if (state == SHIFT) begin
            work  <= shifted;
            count <= count - SHW'(1);
            if (lastStep) begin
                outData <= shifted;
            end
        end
    end

endmodule

// File: tb/tb_shift_right_unit.sv
module tb_shift_right_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        arith;
    logic [4:0]  shamt;
    logic [31:0] inData;
    logic [31:0] outData;
    logic        busy;
    logic        done;

    shift_right_unit #(.WIDTH(32), .SHW(5)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .arith  (arith),
        .shamt  (shamt),
        .inData (inData),
        .outData(outData),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        int          doneCyc;
        int          sh;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          nTests = 0;
    int          nFail = 0;
    int          busyCnt = 0;
    logic [31:0] lastOut = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        nTests++;
        if (act !== expv) begin
            nFail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever done is presented.
    always @(negedge clk) begin
        if (reset) begin
            busyCnt = 0;
            lastOut = '0;
        end else begin
            if (busy) busyCnt++;
            if (done) begin
                if (sb.size() == 0) begin
                    check("extra_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("result", outData, e.data);
                    check("done_cycle", cyc, e.doneCyc);
                    check("busy_cycles", busyCnt, e.sh);
                    check("busy_with_done", {31'd0, busy}, 32'd0);
                end
                busyCnt = 0;
                lastOut = outData;
            end else begin
                check("out_hold", outData, lastOut);
            end
        end
    end

    // Called at a negedge with the unit ready; returns at the negedge after the capture edge.
    task automatic issue(input logic [31:0] d, input int sh, input logic ar,
                         input logic [31:0] expv, input bit push);
        exp_t e;
        inData = d;
        shamt  = 5'(sh);
        arith  = ar;
        start  = 1'b1;
        if (push) begin
            e.data    = expv;
            e.doneCyc = cyc + 1 + sh;
            e.sh      = sh;
            sb.push_back(e);
        end
        @(negedge clk);
        start  = 1'b0;
        inData = $urandom;
        shamt  = 5'($urandom_range(0, 31));
        arith  = 1'($urandom_range(0, 1));
    endtask

    task automatic waitReady();
        int n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("ready_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        arith  = 1'b0;
        shamt  = '0;
        inData = '0;
        repeat (2) @(negedge clk);
        check("rst_out", outData, 32'h0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Directed vectors; each issue lands in IDLE or in the previous DONE cycle.
        issue(32'h8000_0000, 4, 1'b0, 32'h0800_0000, 1'b1); waitReady();
        issue(32'h8000_0000, 4, 1'b1, 32'hF800_0000, 1'b1); waitReady();
        issue(32'h8000_0000, 31, 1'b1, 32'hFFFF_FFFF, 1'b1); waitReady();
        issue(32'h8000_0000, 31, 1'b0, 32'h0000_0001, 1'b1); waitReady();
        issue(32'h1234_5678, 0, 1'b1, 32'h1234_5678, 1'b1); waitReady();
        issue(32'h0040_0010, 2, 1'b0, 32'h0010_0004, 1'b1); waitReady();
        issue(32'h0000_000C, 2, 1'b0, 32'h0000_0003, 1'b1); waitReady();

        // Start while busy must be ignored.
        issue(32'h7FFF_0000, 8, 1'b1, 32'h007F_FF00, 1'b1);
        @(negedge clk);
        inData = 32'hFFFF_FFFF; shamt = 5'd1; arith = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitReady();
        @(negedge clk);

        // Reset in the middle of a shift aborts it without a done pulse.
        waitReady();
        issue(32'hFFFF_0000, 8, 1'b0, 32'h0, 1'b0);
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("abort_out", outData, 32'h0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        issue(32'hFFFF_0000, 8, 1'b0, 32'h00FF_FF00, 1'b1); waitReady();
        issue(32'hFFFF_0000, 8, 1'b1, 32'hFFFF_FF00, 1'b1); waitReady();
        issue(32'h8765_4321, 16, 1'b0, 32'h0000_8765, 1'b1); waitReady();

        repeat (4) @(negedge clk);
        check("sb_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d pending", sb.size());
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/shift_right_unit.md
# shift_right_unit

Iterative multi-cycle right shifter for the MIPS datapath. It performs SRL (logical) and SRA (arithmetic) by a 5-bit shift amount, one bit position per clock, with a start/busy/done handshake. It is the right-shift counterpart of the datapath's fixed left-by-2 shifter: a shift of 2 converts a byte address back into a word index. It also serves the ALU for variable right shifts where a full barrel shifter is not wanted.

## Interface

Parameters:
- WIDTH, 32: data width in bits.
- SHW, 5: shift-amount width; the maximum shift is 2^SHW-1.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high; forces the reset state immediately.
- start  input  1  request; sampled only when the unit is ready.
- arith  input  1  1 = SRA (sign fill), 0 = SRL (zero fill); captured with start.
- shamt  input  SHW  shift amount; captured with start.
- inData  input  WIDTH  operand; captured with start.
- outData  output  WIDTH  registered result; holds its value until the next completion.
- busy  output  1  high while in SHIFT; ready = !busy.
- done  output  1  one-cycle pulse; outData is valid and new in that cycle.

## Operation

- Internal state:
  - FSM with states IDLE, SHIFT, DONE.
  - work register, WIDTH bits.
  - count register, SHW bits.
  - fill bit.
- IDLE or DONE, with start=1:
  - Capture the operands: work<=inData, count<=shamt.
  - fill<=arith & inData[WIDTH-1].
  - If shamt==0: outData<=inData and go to DONE.
  - Otherwise go to SHIFT.
- IDLE or DONE, with start=0: go to IDLE, or stay in IDLE.
- SHIFT, each edge:
  - work<={fill, work[WIDTH-1:1]}.
  - count<=count-1.
  - When count==1 on this edge, outData<={fill, work[WIDTH-1:1]} and go to DONE.
- Start handling:
  - start is ignored while in SHIFT.
  - Captured operands are unaffected by later input changes.
- Outputs:
  - done=1 only in DONE.
  - busy=1 only in SHIFT.
- The DONE state accepts a new start in the same cycle, which gives back-to-back operation.
- Arithmetic:
  - SRL result = inData >> shamt.
  - SRA result = sign-extended inData >>> shamt.
  - No overflow is possible. Bits shifted out are discarded.
- Reset values:
  - state=IDLE.
  - work=0, count=0, fill=0.
  - outData=0, busy=0, done=0.
- Reset mid-operation: the operation is aborted, no done pulse is issued, and outData returns to 0.

## Timing

- Let E0 be the edge that captures start. Latency is shamt+1 edges: done is high in the cycle after edge E(shamt).
  - shamt=0: done in the cycle after E0.
  - shamt=31: done after E31.
- busy:
  - Rises after E0 when shamt>0.
  - Falls at the same edge where done rises.
- Throughput: one operation per shamt+1 cycles when start is held high continuously.
- outData changes only at the edge that enters DONE, or on reset.
- Simultaneous start and done (start while in DONE): the new operands are captured. done is still high for that cycle, with the old result.
- reset asserted asynchronously in any state: all outputs are at their reset values before the next edge.

## Test plan

- SRL: inData=0x80000000, shamt=4, arith=0 -> outData=0x08000000; done pulses exactly once, 5 edges after E0; busy high for 4 cycles.
- SRA: same operands with arith=1 -> 0xF8000000. Also shamt=31 with 0x80000000 -> 0xFFFFFFFF, done after 32 edges.
- shamt=0 with 0x12345678 -> 0x12345678; busy never asserts; done appears the cycle after E0.
- Byte-to-word conversion: 0x00400010, shamt=2, SRL -> 0x00100004. A second start issued in the DONE cycle (0x0000000C, shamt=2) -> 0x00000003 three edges later.
- start pulsed with new operands while busy -> ignored; the first result is unchanged and there is no extra done.
- reset asserted mid-SHIFT (inData 0xFFFF0000, shamt=8, after 3 edges) -> outData=0, busy=0, no done. A subsequent operation completes normally.
